// File: rtl/acc_core_pkg.sv
// acc_core_pkg: shared encodings and instruction field positions for the accumulator core
package acc_core_pkg;
  localparam int INSTR_WIDTH = 16;
  localparam int OPC_LSB     = 12;
  localparam int RIDX_MSB    = 3;
  localparam int ALUR_OP_LSB = 9;
  localparam int ALUI_OP_LSB = 8;
  localparam int IMM_MSB     = 7;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDR  = 4'h2,
    OP_STR  = 4'h3,
    OP_LDM  = 4'h4,
    OP_STM  = 4'h5,
    OP_ALUR = 4'h6,
    OP_ALUI = 4'h7,
    OP_JMP  = 4'h8,
    OP_JC   = 4'h9,
    OP_JZ   = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_PASS
  } alu_op_e;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;
endpackage

// File: rtl/acc_alu.sv
// acc_alu: combinational accumulator ALU with carry/borrow output
module acc_alu
  import acc_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  alu_op_e               i_op,
  input  logic                  i_carry,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry
);
  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_diff;
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + (DATA_WIDTH+1)'(i_op == ALU_ADC && i_carry);
  // top bit of the widened difference is set exactly when i_a < i_b
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign o_result = (i_op == ALU_ADD || i_op == ALU_ADC) ? w_sum[DATA_WIDTH-1:0] :
                    (i_op == ALU_SUB) ? w_diff[DATA_WIDTH-1:0] :
                    (i_op == ALU_AND) ? i_a & i_b :
                    (i_op == ALU_OR)  ? i_a | i_b :
                    (i_op == ALU_XOR) ? i_a ^ i_b :
                    (i_op == ALU_NOT) ? ~i_a : i_b;
  assign o_carry = (i_op == ALU_ADD || i_op == ALU_ADC) ? w_sum[DATA_WIDTH] :
                   (i_op == ALU_SUB) ? w_diff[DATA_WIDTH] : i_carry;
endmodule

// File: rtl/acc_core.sv
// acc_core: multi-cycle parametrised accumulator core with handshaked instruction and data memories
module acc_core
  import acc_core_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int RF_DEPTH       = 4,
  parameter int PC_WIDTH       = 5,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [PC_WIDTH-1:0]       imem_addr,
  input  logic                      imem_valid,
  input  logic [INSTR_WIDTH-1:0]    imem_rdata,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ready,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic [DATA_WIDTH-1:0]     acc,
  output logic                      flag_c,
  output logic                      flag_z,
  output logic                      halted,
  output logic                      illegal_op
);
  localparam int RI_W = RF_DEPTH > 1 ? $clog2(RF_DEPTH) : 1;
  state_e                  r_state;
  logic [PC_WIDTH-1:0]     r_pc;
  logic [INSTR_WIDTH-1:0]  r_ir;
  logic [DATA_WIDTH-1:0]   r_a;
  logic                    r_c;
  logic                    r_z;
  logic [DATA_WIDTH-1:0]   r_rf [RF_DEPTH];
  logic [3:0]              w_op;
  logic [RI_W-1:0]         w_ri;
  logic [DATA_WIDTH-1:0]   w_imm;
  logic [DATA_WIDTH-1:0]   w_res;
  logic                    w_co;
  logic [PC_WIDTH-1:0]     w_tgt;
  logic [PC_WIDTH-1:0]     w_pc_inc;
  alu_op_e                 w_alu_op;
  assign w_op     = r_ir[INSTR_WIDTH-1:OPC_LSB];
  // modulo rather than slicing so non-power-of-two register files still wrap correctly
  assign w_ri     = RI_W'({1'b0, r_ir[RIDX_MSB:0]} % 5'(RF_DEPTH));
  assign w_imm    = DATA_WIDTH'(r_ir[IMM_MSB:0]);
  assign w_tgt    = r_ir[PC_WIDTH-1:0];
  assign w_pc_inc = r_pc + 1'b1;
  assign w_alu_op = alu_op_e'(w_op == OP_ALUR ? r_ir[ALUR_OP_LSB+2:ALUR_OP_LSB]
                                              : r_ir[ALUI_OP_LSB+2:ALUI_OP_LSB]);
  acc_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_a      (r_a),
    .i_b      (w_op == OP_ALUR ? r_rf[w_ri] : w_imm),
    .i_op     (w_alu_op),
    .i_carry  (r_c),
    .o_result (w_res),
    .o_carry  (w_co)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (imem_valid) begin
          r_ir    <= imem_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          r_pc    <= w_pc_inc;
          case (w_op)
            OP_LDI: begin
              r_a <= w_imm;
              r_z <= w_imm == '0;
            end
            OP_LDR: begin
              r_a <= r_rf[w_ri];
              r_z <= r_rf[w_ri] == '0;
            end
            OP_STR: r_rf[w_ri] <= r_a;
            OP_LDM, OP_STM: begin
              r_state <= S_MEM;
              r_pc    <= r_pc;
            end
            OP_ALUR, OP_ALUI: begin
              r_a <= w_res;
              r_c <= w_co;
              r_z <= w_res == '0;
            end
            OP_JMP: r_pc <= w_tgt;
            OP_JC:  r_pc <= r_c ? w_tgt : w_pc_inc;
            OP_JZ:  r_pc <= r_z ? w_tgt : w_pc_inc;
            OP_HALT: begin
              r_state <= S_HALT;
              r_pc    <= r_pc;
            end
            default: ;
          endcase
        end
        S_MEM: if (dmem_ready) begin
          if (w_op == OP_LDM) begin
            r_a <= dmem_rdata;
            r_z <= dmem_rdata == '0;
          end
          r_pc    <= w_pc_inc;
          r_state <= S_FETCH;
        end
        default: ;
      endcase
    end
  end
  // requests are gated by rst so they fall the instant reset asserts
  assign imem_req   = rst && r_state == S_FETCH;
  assign imem_addr  = r_pc;
  assign dmem_req   = rst && r_state == S_MEM;
  assign dmem_we    = dmem_req && w_op == OP_STM;
  assign dmem_addr  = r_ir[MEM_ADDR_WIDTH-1:0];
  assign dmem_wdata = r_a;
  assign acc        = r_a;
  assign flag_c     = r_c;
  assign flag_z     = r_z;
  assign halted     = r_state == S_HALT;
  assign illegal_op = r_state == S_EXEC && w_op >= 4'hB && w_op <= 4'hE;
endmodule

// File: tb/tb_acc_core.sv
// tb_acc_core: directed tests of acc_core with wait-state instruction and data memory models
module tb_acc_core;
  localparam int DW = 8, RD = 4, PW = 5, MW = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic imem_req, imem_valid, dmem_req, dmem_we, dmem_ready;
  logic flag_c, flag_z, halted, illegal_op;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic [MW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata, acc;
  logic [15:0]   prog [32];
  logic [DW-1:0] dmem [1<<MW];
  int idly = 0, ddly = 0, icnt = 0, dcnt = 0;
  int checks = 0, failures = 0;
  int fetch_log[$];
  int stores = 0, st_cycles = 0, ill_cycles = 0;
  logic st_unstable = 1'b0;
  logic [MW-1:0] st_addr;
  logic [DW-1:0] st_data;

  acc_core #(.DATA_WIDTH(DW), .RF_DEPTH(RD), .PC_WIDTH(PW), .MEM_ADDR_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .halted(halted), .illegal_op(illegal_op)
  );

  assign imem_valid = imem_req && icnt >= idly;
  assign imem_rdata = prog[imem_addr];
  assign dmem_ready = dmem_req && dcnt >= ddly;
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (!rst) begin
      icnt <= 0; dcnt <= 0; stores <= 0; st_cycles <= 0; ill_cycles <= 0; st_unstable <= 1'b0;
      fetch_log.delete();
    end else begin
      icnt <= (imem_req && !imem_valid) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
      if (imem_req && imem_valid) fetch_log.push_back(int'(imem_addr));
      if (dmem_req && dmem_we) begin
        if (st_cycles > 0 && (dmem_addr !== st_addr || dmem_wdata !== st_data)) st_unstable <= 1'b1;
        st_addr   <= dmem_addr;
        st_data   <= dmem_wdata;
        st_cycles <= st_cycles + 1;
        if (dmem_ready) begin
          dmem[dmem_addr] <= dmem_wdata;
          stores <= stores + 1;
        end
      end
      if (illegal_op) ill_cycles <= ill_cycles + 1;
    end
  end

  task clear_prog;
    for (int i = 0; i < 32; i++) prog[i] = 16'hF000;
  endtask

  task hold_reset;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task run(output int n);
    @(negedge clk) rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < 500);
  endtask

  task test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({imem_req, dmem_req} !== 2'b00) begin failures++; $display("FAIL reset_req: got %b exp 00", {imem_req, dmem_req}); end
    checks++; if (acc !== 8'h00) begin failures++; $display("FAIL reset_acc: got %h exp 00", acc); end
    checks++; if ({flag_c, flag_z, halted, illegal_op} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b exp 0000", {flag_c, flag_z, halted, illegal_op}); end
    checks++; if (imem_addr !== 5'd0) begin failures++; $display("FAIL reset_pc: got %h exp 00", imem_addr); end
  endtask

  task test_reset_mid_mem;
    int n;
    clear_prog;
    prog[0] = 16'h115A;
    prog[1] = 16'h53FF;
    ddly = 1000;
    hold_reset;
    @(negedge clk) rst = 1'b1;
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL midmem_req: got %b exp 1", dmem_req); end
    checks++; if ({dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 10'h3FF, 8'h5A}) begin failures++; $display("FAIL midmem_bus: got %h exp %h", {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 10'h3FF, 8'h5A}); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({dmem_req, imem_req} !== 2'b00) begin failures++; $display("FAIL midmem_drop: got %b exp 00", {dmem_req, imem_req}); end
    checks++; if (acc !== 8'h00) begin failures++; $display("FAIL midmem_acc: got %h exp 00", acc); end
    ddly = 0;
    clear_prog;
    @(negedge clk);
    run(n);
    checks++; if (fetch_log.size() !== 1 || halted !== 1'b1) begin failures++; $display("FAIL midmem_refetch_n: got %0d exp 1", fetch_log.size()); end
    else begin
      checks++; if (fetch_log[0] !== 0) begin failures++; $display("FAIL midmem_refetch_addr: got %0d exp 0", fetch_log[0]); end
    end
  endtask

  task test_add_carry;
    int n;
    clear_prog;
    prog[0] = 16'h11FF;
    prog[1] = 16'h7001;
    hold_reset;
    run(n);
    checks++; if (n !== 6) begin failures++; $display("FAIL add_cycles: got %0d exp 6", n); end
    checks++; if ({acc, flag_c, flag_z} !== {8'h00, 1'b1, 1'b1}) begin failures++; $display("FAIL add_wrap: got %h exp %h", {acc, flag_c, flag_z}, {8'h00, 2'b11}); end
    prog[2] = 16'h7100;
    hold_reset;
    run(n);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL adc_halt: got %b exp 1", halted); end
    checks++; if ({acc, flag_c, flag_z} !== {8'h01, 1'b0, 1'b0}) begin failures++; $display("FAIL adc: got %h exp %h", {acc, flag_c, flag_z}, {8'h01, 2'b00}); end
  endtask

  task test_sub_jumps;
    int n;
    idly = 1;
    clear_prog;
    prog[0]  = 16'h1105;
    prog[1]  = 16'h7207;
    prog[2]  = 16'h9010;
    prog[16] = 16'hA005;
    hold_reset;
    run(n);
    checks++; if ({acc, flag_c, flag_z} !== {8'hFE, 1'b1, 1'b0}) begin failures++; $display("FAIL sub_borrow: got %h exp %h", {acc, flag_c, flag_z}, {8'hFE, 2'b10}); end
    checks++; if (fetch_log.size() !== 5) begin failures++; $display("FAIL jump_count: got %0d exp 5", fetch_log.size()); end
    else begin
      checks++; if (fetch_log[3] !== 16) begin failures++; $display("FAIL jc_taken: got %0d exp 16", fetch_log[3]); end
      checks++; if (fetch_log[4] !== 17) begin failures++; $display("FAIL jz_not_taken: got %0d exp 17", fetch_log[4]); end
    end
    idly = 0;
  endtask

  task test_regfile;
    int n;
    clear_prog;
    prog[0] = 16'h110F;
    prog[1] = 16'h3001;
    prog[2] = 16'h113C;
    prog[3] = 16'h6801;
    prog[4] = 16'h3006;
    prog[5] = 16'h1100;
    prog[6] = 16'h2002;
    prog[7] = 16'h6A01;
    prog[8] = 16'h7600;
    prog[9] = 16'h72CF;
    hold_reset;
    run(n);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rf_halt: got %b exp 1", halted); end
    checks++; if ({acc, flag_c, flag_z} !== {8'h00, 1'b0, 1'b1}) begin failures++; $display("FAIL rf_alu: got %h exp %h", {acc, flag_c, flag_z}, {8'h00, 2'b01}); end
  endtask

  task test_mem_wait;
    int n;
    ddly = 3;
    clear_prog;
    prog[0] = 16'h11A5;
    prog[1] = 16'h53FF;
    prog[2] = 16'h1100;
    prog[3] = 16'h43FF;
    hold_reset;
    run(n);
    checks++; if (n !== 18) begin failures++; $display("FAIL mem_cycles: got %0d exp 18", n); end
    checks++; if (stores !== 1) begin failures++; $display("FAIL mem_store_count: got %0d exp 1", stores); end
    checks++; if (st_cycles !== 4) begin failures++; $display("FAIL mem_req_cycles: got %0d exp 4", st_cycles); end
    checks++; if (st_unstable !== 1'b0) begin failures++; $display("FAIL mem_stable: got %b exp 0", st_unstable); end
    checks++; if (dmem[10'h3FF] !== 8'hA5) begin failures++; $display("FAIL mem_stored: got %h exp a5", dmem[10'h3FF]); end
    checks++; if ({acc, flag_z} !== {8'hA5, 1'b0}) begin failures++; $display("FAIL mem_load: got %h exp %h", {acc, flag_z}, {8'hA5, 1'b0}); end
    ddly = 0;
  endtask

  task test_wrap_illegal;
    int n;
    clear_prog;
    prog[0]  = 16'h9004;
    prog[1]  = 16'h11FF;
    prog[2]  = 16'h7001;
    prog[3]  = 16'h801F;
    prog[31] = 16'h0000;
    prog[4]  = 16'hC000;
    hold_reset;
    run(n);
    checks++; if (fetch_log.size() !== 8) begin failures++; $display("FAIL wrap_count: got %0d exp 8", fetch_log.size()); end
    else begin
      checks++; if ({fetch_log[4], fetch_log[5], fetch_log[6]} !== {32'd31, 32'd0, 32'd4}) begin failures++; $display("FAIL pc_wrap: got %0d %0d %0d exp 31 0 4", fetch_log[4], fetch_log[5], fetch_log[6]); end
    end
    checks++; if (ill_cycles !== 1) begin failures++; $display("FAIL illegal_pulse: got %0d exp 1", ill_cycles); end
    checks++; if ({acc, flag_c, flag_z} !== {8'h00, 1'b1, 1'b1}) begin failures++; $display("FAIL illegal_state: got %h exp %h", {acc, flag_c, flag_z}, {8'h00, 2'b11}); end
  endtask

  task test_halt;
    int k, n;
    k = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req) k++;
    end
    checks++; if (k !== 0) begin failures++; $display("FAIL halt_no_fetch: got %0d exp 0", k); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky: got %b exp 1", halted); end
    clear_prog;
    prog[0] = 16'h1133;
    hold_reset;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset: got %b exp 0", halted); end
    run(n);
    checks++; if (fetch_log.size() !== 2) begin failures++; $display("FAIL halt_resume_n: got %0d exp 2", fetch_log.size()); end
    else begin
      checks++; if (fetch_log[0] !== 0) begin failures++; $display("FAIL halt_resume_addr: got %0d exp 0", fetch_log[0]); end
    end
    checks++; if (acc !== 8'h33) begin failures++; $display("FAIL halt_resume_acc: got %h exp 33", acc); end
  endtask

  initial begin
    clear_prog;
    test_reset;
    test_reset_mid_mem;
    test_add_carry;
    test_sub_jumps;
    test_regfile;
    test_mem_wait;
    test_wrap_illegal;
    test_halt;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
